// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable bit-period divider.
// Register window: TXDATA, STATUS, BAUDDIV and a reserved word, all at 32-bit offsets.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        nRD,
  input  logic        nWR,
  output logic [31:0] Dataout,
  output logic        tx,
  output logic        txIrq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic          hit;
  logic [1:0]    offset;
  logic          push_req;
  logic          stat_wr;
  logic          div_wr;
  logic          push_ok;
  logic          pop;
  logic          empty;
  logic          full;
  logic          busy;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic [15:0]   baud_q;

  state_e        state_q, state_d;
  logic [15:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic [2:0]    next_idx;

  logic          unused_bits;
  assign unused_bits = ^{address[1:0], writeData[31:16]};

  assign hit      = (address[31:4] == BASE_ADDR[31:4]);
  assign offset   = address[3:2];
  assign push_req = hit && !nWR && (offset == 2'd0);
  assign stat_wr  = hit && !nWR && (offset == 2'd1);
  assign div_wr   = hit && !nWR && (offset == 2'd2);

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the transmitter pops on the same edge.
  assign push_ok = push_req && (!full || pop);
  assign busy    = (state_q != StIdle);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= writeData[7:0];
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_q     <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      // A dropped push sets overflow even if the same cycle tries to clear it.
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (stat_wr && writeData[3]) begin
        overflow_q <= 1'b0;
      end
      if (div_wr) baud_q <= writeData[15:0];
    end
  end

  assign bit_end  = (bit_cnt_q == 16'd0);
  assign next_idx = bit_idx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_cnt_d = baud_q;
          state_d   = StStart;
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          bit_cnt_d = baud_q;
          tx_d      = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          bit_cnt_d = baud_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (!empty) begin
            // Chain straight into the next frame without an idle cycle.
            pop       = 1'b1;
            shift_d   = mem[rd_ptr_q];
            bit_cnt_d = baud_q;
            state_d   = StStart;
            tx_d      = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    Dataout = 32'h0;
    if (!nRD && hit) begin
      case (offset)
        2'd1:    Dataout = {16'h0, 8'(count_q), 4'h0, overflow_q, empty, full, busy};
        2'd2:    Dataout = {16'h0, baud_q};
        default: Dataout = 32'h0;
      endcase
    end
  end

  assign tx    = tx_q;
  assign txIrq = empty && (state_q == StIdle);

endmodule
